// File: rtl/mc_ctrl.sv
// mc_ctrl: multi-cycle control unit for the single-ALU, shared-memory MIPS
// datapath. It walks each instruction through FETCH/DCD/EXE/MEM/WB and
// Moore-decodes every datapath control from the state, the registered
// opcode/funct and the ALU flags latched in EXE. It also counts retired
// instructions and raises a sticky flag on illegal encodings.
module mc_ctrl #(
   parameter int COUNT_W      = 32,
   parameter int ILLEGAL_HALT = 1
) (
   input  logic               clk,
   input  logic               rst,
   input  logic [5:0]         opcode,
   input  logic [5:0]         funct,
   input  logic               zero,
   input  logic               overflow,
   input  logic               signed_less,
   output logic [1:0]         alu_ctl,
   output logic               ext_op,
   output logic               alu_src,
   output logic [1:0]         reg_dst,
   output logic [2:0]         reg_src,
   output logic [1:0]         npc_sel,
   output logic               mem_op,
   output logic               mem_write,
   output logic               reg_write,
   output logic               pc_write,
   output logic               rgs_ins_write,
   output logic [2:0]         state,
   output logic               illegal,
   output logic [COUNT_W-1:0] instr_count
);

   localparam logic [2:0] S_FETCH  = 3'd0;
   localparam logic [2:0] S_DCD    = 3'd1;
   localparam logic [2:0] S_EXE    = 3'd2;
   localparam logic [2:0] S_MEM_RD = 3'd3;
   localparam logic [2:0] S_MEM_WR = 3'd4;
   localparam logic [2:0] S_WB     = 3'd5;
   localparam logic [2:0] S_HALT   = 3'd6;

   logic [2:0]         r_state;
   logic [2:0]         w_next;
   logic               w_last;
   logic               r_illegal;
   logic               r_ovf;
   logic               r_slt;
   logic [COUNT_W-1:0] r_count;

   // Instruction decode from the instruction-register fields
   logic w_rtype, w_addu, w_subu, w_slt, w_jr;
   logic w_ori, w_addi, w_lw, w_lb, w_sw, w_sb, w_beq, w_j, w_jal;
   logic w_load, w_store, w_byte, w_legal, w_jump;

   assign w_rtype = (opcode == 6'h00);
   assign w_addu  = w_rtype && (funct == 6'h21);
   assign w_subu  = w_rtype && (funct == 6'h23);
   assign w_slt   = w_rtype && (funct == 6'h2A);
   assign w_jr    = w_rtype && (funct == 6'h08);
   assign w_ori   = (opcode == 6'h0D);
   assign w_addi  = (opcode == 6'h08);
   assign w_lw    = (opcode == 6'h23);
   assign w_lb    = (opcode == 6'h20);
   assign w_sw    = (opcode == 6'h2B);
   assign w_sb    = (opcode == 6'h28);
   assign w_beq   = (opcode == 6'h04);
   assign w_j     = (opcode == 6'h02);
   assign w_jal   = (opcode == 6'h03);
   assign w_load  = w_lw || w_lb;
   assign w_store = w_sw || w_sb;
   assign w_byte  = w_lb || w_sb;
   assign w_jump  = w_j || w_jal || w_jr;
   assign w_legal = w_addu || w_subu || w_slt || w_jr || w_ori || w_addi ||
                    w_load || w_store || w_beq || w_j || w_jal;

   // Next-state selection; w_last marks the final cycle of an instruction
   always_comb begin
      w_next = S_FETCH;
      w_last = 1'b0;
      case (r_state)
         S_FETCH: w_next = S_DCD;
         S_DCD: begin
            if (!w_legal) begin
               if (ILLEGAL_HALT != 0) begin
                  w_next = S_HALT;
               end else begin
                  w_next = S_FETCH;
                  w_last = 1'b1;
               end
            end else if (w_jump) begin
               w_next = S_FETCH;
               w_last = 1'b1;
            end else begin
               w_next = S_EXE;
            end
         end
         S_EXE: begin
            if (w_load) begin
               w_next = S_MEM_RD;
            end else if (w_store) begin
               w_next = S_MEM_WR;
            end else if (w_beq) begin
               w_next = S_FETCH;
               w_last = 1'b1;
            end else begin
               w_next = S_WB;
            end
         end
         S_MEM_RD: w_next = S_WB;
         S_MEM_WR: begin
            w_next = S_FETCH;
            w_last = 1'b1;
         end
         S_WB: begin
            w_next = S_FETCH;
            w_last = 1'b1;
         end
         S_HALT:  w_next = S_HALT;
         default: w_next = S_FETCH;
      endcase
   end

   // State, sticky illegal flag, EXE flag latches and retire counter
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         r_state   <= S_FETCH;
         r_illegal <= 1'b0;
         r_ovf     <= 1'b0;
         r_slt     <= 1'b0;
         r_count   <= '0;
      end else begin
         r_state <= w_next;
         if (r_state == S_DCD && !w_legal) begin
            r_illegal <= 1'b1;
         end
         if (r_state == S_EXE) begin
            r_ovf <= overflow;
            r_slt <= signed_less;
         end
         if (w_last) begin
            r_count <= r_count + COUNT_W'(1);
         end
      end
   end

   // Moore control decode; everything is held low while reset is asserted
   always_comb begin
      alu_ctl       = 2'b00;
      ext_op        = 1'b0;
      alu_src       = 1'b0;
      reg_dst       = 2'b00;
      reg_src       = 3'b000;
      npc_sel       = 2'b00;
      mem_op        = 1'b0;
      mem_write     = 1'b0;
      reg_write     = 1'b0;
      pc_write      = 1'b0;
      rgs_ins_write = 1'b0;
      if (!rst) begin
         // ALU/extender/memory-width selects stay stable from EXE onward
         if (r_state == S_EXE || r_state == S_MEM_RD ||
             r_state == S_MEM_WR || r_state == S_WB) begin
            mem_op = w_byte;
            if (w_subu || w_slt || w_beq) begin
               alu_ctl = 2'b01;
            end else if (w_ori) begin
               alu_ctl = 2'b10;
               alu_src = 1'b1;
            end else if (w_addi) begin
               alu_ctl = 2'b11;
               alu_src = 1'b1;
               ext_op  = 1'b1;
            end else if (w_load || w_store) begin
               alu_src = 1'b1;
               ext_op  = 1'b1;
            end
         end
         case (r_state)
            S_FETCH: begin
               rgs_ins_write = 1'b1;
               pc_write      = 1'b1;
            end
            S_DCD: begin
               if (w_jr) begin
                  pc_write = 1'b1;
                  npc_sel  = 2'b11;
               end else if (w_j || w_jal) begin
                  pc_write = 1'b1;
                  npc_sel  = 2'b10;
                  if (w_jal) begin
                     reg_write = 1'b1;
                     reg_dst   = 2'b11;
                     reg_src   = 3'b100;
                  end
               end
            end
            S_EXE: begin
               if (w_beq && zero) begin
                  pc_write = 1'b1;
                  npc_sel  = 2'b01;
               end
            end
            S_MEM_WR: mem_write = 1'b1;
            S_WB: begin
               reg_write = 1'b1;
               if (w_rtype) begin
                  reg_dst = 2'b00;
                  if (w_slt) begin
                     reg_src = r_slt ? 3'b011 : 3'b010;
                  end
               end else if (w_addi && r_ovf) begin
                  // Overflow records a 1 into $30 and leaves rt untouched
                  reg_dst = 2'b10;
                  reg_src = 3'b011;
               end else if (w_load) begin
                  reg_dst = 2'b01;
                  reg_src = 3'b001;
               end else begin
                  reg_dst = 2'b01;
               end
            end
            default: ;
         endcase
      end
   end

   assign state       = r_state;
   assign illegal     = r_illegal;
   assign instr_count = r_count;

endmodule

// File: tb/tb_mc_ctrl.sv
// Directed bench for mc_ctrl: walks a fixed instruction stream through the
// controller and compares state/control outputs against hand-derived values.
// A second instance with ILLEGAL_HALT=0 sees the same stimulus.
module tb_mc_ctrl;

   logic        clk = 1'b0;
   logic        rst = 1'b1;
   logic [5:0]  opcode = 6'h00;
   logic [5:0]  funct = 6'h00;
   logic        zero = 1'b0;
   logic        overflow = 1'b0;
   logic        signed_less = 1'b0;

   logic [1:0]  alu_ctl, reg_dst, npc_sel;
   logic        ext_op, alu_src, mem_op, mem_write, reg_write, pc_write, rgs_ins_write;
   logic [2:0]  reg_src, state;
   logic        illegal;
   logic [31:0] instr_count;

   logic [1:0]  nh_alu_ctl, nh_reg_dst, nh_npc_sel;
   logic        nh_ext_op, nh_alu_src, nh_mem_op, nh_mem_write, nh_reg_write;
   logic        nh_pc_write, nh_rgs_ins_write;
   logic [2:0]  nh_reg_src, nh_state;
   logic        nh_illegal;
   logic [31:0] nh_instr_count;

   logic [15:0] w_ctl;
   assign w_ctl = {alu_ctl, ext_op, alu_src, reg_dst, reg_src, npc_sel,
                   mem_op, mem_write, reg_write, pc_write, rgs_ins_write};

   int n_checks = 0;
   int n_errors = 0;

   mc_ctrl #(.COUNT_W(32), .ILLEGAL_HALT(1)) u_dut (
      .clk(clk), .rst(rst), .opcode(opcode), .funct(funct), .zero(zero),
      .overflow(overflow), .signed_less(signed_less), .alu_ctl(alu_ctl),
      .ext_op(ext_op), .alu_src(alu_src), .reg_dst(reg_dst), .reg_src(reg_src),
      .npc_sel(npc_sel), .mem_op(mem_op), .mem_write(mem_write),
      .reg_write(reg_write), .pc_write(pc_write), .rgs_ins_write(rgs_ins_write),
      .state(state), .illegal(illegal), .instr_count(instr_count)
   );

   mc_ctrl #(.COUNT_W(32), .ILLEGAL_HALT(0)) u_dut_nh (
      .clk(clk), .rst(rst), .opcode(opcode), .funct(funct), .zero(zero),
      .overflow(overflow), .signed_less(signed_less), .alu_ctl(nh_alu_ctl),
      .ext_op(nh_ext_op), .alu_src(nh_alu_src), .reg_dst(nh_reg_dst),
      .reg_src(nh_reg_src), .npc_sel(nh_npc_sel), .mem_op(nh_mem_op),
      .mem_write(nh_mem_write), .reg_write(nh_reg_write), .pc_write(nh_pc_write),
      .rgs_ins_write(nh_rgs_ins_write), .state(nh_state), .illegal(nh_illegal),
      .instr_count(nh_instr_count)
   );

   always #5 clk = ~clk;

   task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_checks++;
      if (got !== exp) begin
         n_errors++;
         $display("FAIL %s: got %0h expected %0h", tag, got, exp);
      end
   endtask

   task automatic tick(input string tag, input logic [2:0] exp_st);
      @(posedge clk);
      #1;
      chk({tag, ".state"}, {29'd0, state}, {29'd0, exp_st});
   endtask

   task automatic start(input string tag, input logic [5:0] op, input logic [5:0] fn);
      opcode = op;
      funct  = fn;
      $display("instr %s op=%02h fn=%02h count=%0d", tag, op, fn, instr_count);
   endtask

   initial begin
      // Reset values, strobes forced low even though the state is FETCH
      repeat (2) @(posedge clk);
      #1;
      chk("rst.state", {29'd0, state}, 32'd0);
      chk("rst.ctl", {16'd0, w_ctl}, 32'd0);
      chk("rst.cnt", instr_count, 32'd0);
      chk("rst.ill", {31'd0, illegal}, 32'd0);
      rst = 1'b0;
      #1;
      chk("rel.fetch", {29'd0, rgs_ins_write, pc_write, 1'b0}, {29'd0, 3'b110});

      // j: retires in DCD
      start("j", 6'h02, 6'h00);
      tick("j", 3'd1);
      chk("j.pc", {29'd0, pc_write, npc_sel}, {29'd0, 3'b110});
      tick("j", 3'd0);
      chk("j.cnt", instr_count, 32'd1);

      // addu interrupted by reset in EXE
      start("addu_rst", 6'h00, 6'h21);
      tick("addu_rst", 3'd1);
      tick("addu_rst", 3'd2);
      rst = 1'b1;
      #1;
      chk("midrst.state", {29'd0, state}, 32'd0);
      chk("midrst.ctl", {16'd0, w_ctl}, 32'd0);
      chk("midrst.cnt", instr_count, 32'd0);
      @(posedge clk);
      #1;
      rst = 1'b0;
      #1;
      chk("midrst.fetch", {30'd0, rgs_ins_write, pc_write}, 32'd3);

      // addu then lw: 4 + 5 cycles
      start("addu", 6'h00, 6'h21);
      tick("addu", 3'd1);
      tick("addu", 3'd2);
      chk("addu.exe", {29'd0, alu_ctl, alu_src}, 32'd0);
      tick("addu", 3'd5);
      chk("addu.wb", {26'd0, reg_write, reg_dst, reg_src}, {26'd0, 6'b100000});
      tick("addu", 3'd0);
      start("lw", 6'h23, 6'h00);
      tick("lw", 3'd1);
      tick("lw", 3'd2);
      chk("lw.exe", {27'd0, alu_ctl, mem_op, alu_src, ext_op}, {27'd0, 5'b00011});
      tick("lw", 3'd3);
      chk("lw.mrd", {28'd0, mem_op, alu_src, ext_op, reg_write}, {28'd0, 4'b0110});
      tick("lw", 3'd5);
      chk("lw.wb", {25'd0, reg_write, reg_dst, reg_src, mem_op}, {25'd0, 7'b1010010});
      tick("lw", 3'd0);
      chk("lw.cnt", instr_count, 32'd2);

      // beq taken then not taken
      start("beq_t", 6'h04, 6'h00);
      zero = 1'b1;
      tick("beq_t", 3'd1);
      tick("beq_t", 3'd2);
      chk("beq_t.exe", {27'd0, pc_write, npc_sel, alu_ctl}, {27'd0, 5'b10101});
      tick("beq_t", 3'd0);
      zero = 1'b0;
      chk("beq_t.cnt", instr_count, 32'd3);
      start("beq_n", 6'h04, 6'h00);
      tick("beq_n", 3'd1);
      tick("beq_n", 3'd2);
      chk("beq_n.exe", {29'd0, pc_write, npc_sel}, 32'd0);
      tick("beq_n", 3'd0);
      chk("beq_n.cnt", instr_count, 32'd4);

      // addi with overflow, flag dropped after EXE to exercise the latch
      start("addi_ovf", 6'h08, 6'h00);
      tick("addi_ovf", 3'd1);
      tick("addi_ovf", 3'd2);
      overflow = 1'b1;
      chk("addi_ovf.exe", {28'd0, alu_ctl, alu_src, ext_op}, {28'd0, 4'b1111});
      tick("addi_ovf", 3'd5);
      overflow = 1'b0;
      #1;
      chk("addi_ovf.wb", {26'd0, reg_write, reg_dst, reg_src}, {26'd0, 6'b110011});
      tick("addi_ovf", 3'd0);
      start("addi", 6'h08, 6'h00);
      tick("addi", 3'd1);
      tick("addi", 3'd2);
      tick("addi", 3'd5);
      chk("addi.wb", {26'd0, reg_write, reg_dst, reg_src}, {26'd0, 6'b101000});
      tick("addi", 3'd0);
      chk("addi.cnt", instr_count, 32'd6);

      // jal: link write and jump in DCD
      start("jal", 6'h03, 6'h00);
      tick("jal", 3'd1);
      chk("jal.dcd", {23'd0, reg_write, reg_dst, reg_src, pc_write, npc_sel},
          {23'd0, 9'b1_11_100_1_10});
      tick("jal", 3'd0);
      chk("jal.cnt", instr_count, 32'd7);

      // sb: byte store, single-cycle mem_write
      start("sb", 6'h28, 6'h00);
      tick("sb", 3'd1);
      tick("sb", 3'd2);
      chk("sb.exe", {29'd0, mem_op, mem_write, reg_write}, {29'd0, 3'b100});
      tick("sb", 3'd4);
      chk("sb.mwr", {29'd0, mem_op, mem_write, reg_write}, {29'd0, 3'b110});
      tick("sb", 3'd0);
      chk("sb.cnt", instr_count, 32'd8);

      // slt with signed_less latched
      start("slt", 6'h00, 6'h2A);
      tick("slt", 3'd1);
      tick("slt", 3'd2);
      signed_less = 1'b1;
      chk("slt.exe", {30'd0, alu_ctl}, 32'd1);
      tick("slt", 3'd5);
      signed_less = 1'b0;
      #1;
      chk("slt.wb", {27'd0, reg_dst, reg_src}, {27'd0, 5'b00011});
      tick("slt", 3'd0);
      chk("slt.cnt", instr_count, 32'd9);

      // illegal opcode: halting instance parks, the other retires it
      start("illegal", 6'h3F, 6'h00);
      tick("illegal", 3'd1);
      tick("illegal", 3'd6);
      chk("ill.flag", {31'd0, illegal}, 32'd1);
      chk("ill_nh.state", {29'd0, nh_state}, 32'd0);
      chk("ill_nh.flag", {31'd0, nh_illegal}, 32'd1);
      chk("ill_nh.cnt", nh_instr_count, 32'd10);
      for (int i = 0; i < 20; i++) begin
         @(posedge clk);
         #1;
         chk("halt.hold", {13'd0, state, w_ctl}, {13'd0, 3'd6, 16'd0});
      end
      chk("halt.cnt", instr_count, 32'd9);

      $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
      $finish;
   end

endmodule
